// File: rtl/ac_i2c_slave.sv
// Write-only I2C slave for the SSM2603 codec control port: 7-bit register address plus
// 9-bit data per transfer, with a 32x9 shadow register file readable on dbg_addr.
module ac_i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       reg_wr,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  input  logic [4:0] dbg_addr,
  output logic [8:0] dbg_data,
  output logic       busy
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE} state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through every line-conditioning stage.
  logic [1:0]    sync_p0, sync_p1, filt_p2, filt_d;
  logic [CW-1:0] filt_cnt [2];

  state_t      state, state_nxt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg, byte1;
  logic        sda_oe_d, commit, busy_d;
  logic [8:0]  regs [32];

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, shifting;

  // Stage p0/p1: two-flop synchronizer; stage p2: level accepted after FILT_LEN equal samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0     <= 2'b11;
      sync_p1     <= 2'b11;
      filt_p2     <= 2'b11;
      filt_d      <= 2'b11;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
    end else begin
      sync_p0 <= {sda_i, scl_i};
      sync_p1 <= sync_p0;
      filt_d  <= filt_p2;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == CW'(FILT_LEN - 1)) begin
          filt_p2[i]  <= sync_p1[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_f     = filt_p2[0];
  assign sda_f     = filt_p2[1];
  assign scl_rise  = scl_f & ~filt_d[0];
  assign scl_fall  = ~scl_f & filt_d[0];
  assign start_det = scl_f & filt_d[0] & filt_d[1] & ~sda_f;
  assign stop_det  = scl_f & filt_d[0] & ~filt_d[1] & sda_f;
  assign shifting  = (state == ADDR) || (state == BYTE1) || (state == BYTE2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Every ACK decision and release is taken on a filtered SCL falling edge.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else if (scl_fall) begin
      case (state)
        ADDR:    if (bit_cnt == 4'd8)
                   state_nxt = (shreg[7:1] == DEV_ADDR && !shreg[0]) ? ACK_A : IGNORE;
        ACK_A:   state_nxt = BYTE1;
        BYTE1:   if (bit_cnt == 4'd8) state_nxt = ACK_1;
        ACK_1:   state_nxt = BYTE2;
        BYTE2:   if (bit_cnt == 4'd8) state_nxt = ACK_2;
        ACK_2:   state_nxt = IGNORE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    sda_oe_d = 1'b0;
    commit   = (state == ACK_2) && (state_nxt == IGNORE);
    busy_d   = (state_nxt != IDLE);
    case (state_nxt)
      ACK_A, ACK_1, ACK_2: sda_oe_d = 1'b1;
      default:             sda_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      byte1    <= '0;
      sda_oe   <= 1'b0;
      reg_wr   <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      sda_oe <= sda_oe_d;
      busy   <= busy_d;
      reg_wr <= commit;
      if (start_det || state_nxt != state) begin
        bit_cnt <= '0;
      end else if (scl_rise && shifting && bit_cnt != 4'd8) begin
        shreg   <= {shreg[6:0], sda_f};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == BYTE1 && state_nxt == ACK_1) byte1 <= shreg;
      if (commit) begin
        reg_addr <= byte1[7:1];
        reg_data <= {byte1[0], shreg};
        // Register 0x0F is the codec software reset and wipes the whole shadow file.
        if (byte1[7:1] == 7'h0F) begin
          for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (byte1[7:6] == 2'b00) begin
          regs[byte1[5:1]] <= {byte1[0], shreg};
        end
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_ac_i2c_slave.sv
// Directed bench for ac_i2c_slave: a bit-banged I2C master with an open-drain SDA model.
module tb_ac_i2c_slave;

  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_oe, reg_wr, busy;
  logic [6:0] reg_addr;
  logic [8:0] reg_data, dbg_data;
  logic [4:0] dbg_addr = '0;

  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  logic oe_seen = 1'b0;
  logic ack;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  ac_i2c_slave #(.DEV_ADDR(7'h1A), .FILT_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr) wr_cnt = wr_cnt + 1;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(2 * Q);
  endtask

  // Eight data clocks then the ACK clock; ack is the slave's drive at mid ACK-high.
  task automatic write_byte(input logic [7:0] d, input logic glitch, output logic a);
    for (int i = 7; i >= 0; i--) begin
      sda_m = d[i]; wait_clks(Q);
      scl_m = 1'b1;
      if (glitch && i == 7) begin
        wait_clks(Q - 2);
        sda_m = ~d[i]; wait_clks(1);
        sda_m = d[i];  wait_clks(Q + 1);
      end else begin
        wait_clks(2 * Q);
      end
      scl_m = 1'b0; wait_clks(Q);
    end
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    a = sda_oe;
    wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic write_reg(input logic [6:0] ra, input logic [8:0] rd, input string tag);
    i2c_start();
    write_byte(8'h34, 1'b0, ack);          check({tag, "_ack_dev"}, ack, 1);
    write_byte({ra, rd[8]}, 1'b0, ack);    check({tag, "_ack_b1"}, ack, 1);
    write_byte(rd[7:0], 1'b0, ack);        check({tag, "_ack_b2"}, ack, 1);
    i2c_stop();
  endtask

  initial begin
    // Reset state
    wait_clks(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_data", reg_data, 0);
    check("rst_busy", busy, 0);
    check("rst_dbg0", dbg_data, 0);
    reset_n = 1'b1;
    wait_clks(10);

    // Basic write: reg 0x07 <= 0x04A
    i2c_start();
    write_byte(8'h34, 1'b0, ack); check("t1_ack_dev", ack, 1);
    check("t1_busy", busy, 1);
    write_byte(8'h0E, 1'b0, ack); check("t1_ack_b1", ack, 1);
    write_byte(8'h4A, 1'b0, ack); check("t1_ack_b2", ack, 1);
    i2c_stop();
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_reg_addr", reg_addr, 7'h07);
    check("t1_reg_data", reg_data, 9'h04A);
    dbg_addr = 5'd7; #1;
    check("t1_dbg7", dbg_data, 9'h04A);
    check("t1_busy_after_stop", busy, 0);

    // Wrong device address
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h36, 1'b0, ack); check("t2_nack_dev", ack, 0);
    write_byte(8'h0E, 1'b0, ack); check("t2_nack_b1", ack, 0);
    write_byte(8'h55, 1'b0, ack); check("t2_nack_b2", ack, 0);
    i2c_stop();
    check("t2_oe_never", oe_seen, 0);
    check("t2_wr_cnt", wr_cnt, 1);

    // Read request is refused but the bus stays claimed until STOP
    i2c_start();
    write_byte(8'h35, 1'b0, ack); check("t3_nack_read", ack, 0);
    check("t3_busy", busy, 1);
    write_byte(8'hFF, 1'b0, ack); check("t3_busy_late", busy, 1);
    i2c_stop();
    check("t3_busy_after_stop", busy, 0);
    check("t3_wr_cnt", wr_cnt, 1);

    // Repeated START discards the partial transfer
    i2c_start();
    write_byte(8'h34, 1'b0, ack); check("t4_ack_dev_a", ack, 1);
    write_byte(8'h0E, 1'b0, ack); check("t4_ack_b1_a", ack, 1);
    i2c_start();
    write_byte(8'h34, 1'b0, ack); check("t4_ack_dev_b", ack, 1);
    write_byte(8'h10, 1'b0, ack); check("t4_ack_b1_b", ack, 1);
    write_byte(8'h01, 1'b0, ack); check("t4_ack_b2_b", ack, 1);
    i2c_stop();
    check("t4_wr_cnt", wr_cnt, 2);
    check("t4_reg_addr", reg_addr, 7'h08);
    check("t4_reg_data", reg_data, 9'h001);
    dbg_addr = 5'd8; #1; check("t4_dbg8", dbg_data, 9'h001);
    dbg_addr = 5'd7; #1; check("t4_dbg7_kept", dbg_data, 9'h04A);

    // Full-width data, out-of-range address, then software reset
    write_reg(7'h03, 9'h1FF, "t5_r3");
    dbg_addr = 5'd3; #1; check("t5_dbg3", dbg_data, 9'h1FF);
    write_reg(7'h20, 9'h155, "t5_r32");
    check("t5_wr_cnt_r32", wr_cnt, 4);
    check("t5_reg_addr_r32", reg_addr, 7'h20);
    dbg_addr = 5'd0; #1; check("t5_dbg0_untouched", dbg_data, 9'h000);
    write_reg(7'h0F, 9'h000, "t5_swrst");
    check("t5_wr_cnt_swrst", wr_cnt, 5);
    check("t5_reg_addr_swrst", reg_addr, 7'h0F);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0]; #1;
      check($sformatf("t5_clear_%0d", a), dbg_data, 9'h000);
    end

    // SDA glitches while SCL is high must not be seen as START/STOP
    sda_m = 1'b0; wait_clks(1); sda_m = 1'b1; wait_clks(3 * Q);
    check("t6_idle_glitch_busy", busy, 0);
    i2c_start();
    write_byte(8'h34, 1'b0, ack); check("t6_ack_dev", ack, 1);
    write_byte(8'h0E, 1'b0, ack); check("t6_ack_b1", ack, 1);
    write_byte(8'h4A, 1'b1, ack); check("t6_ack_b2_glitch", ack, 1);
    i2c_stop();
    check("t6_wr_cnt", wr_cnt, 6);
    dbg_addr = 5'd7; #1; check("t6_dbg7", dbg_data, 9'h04A);

    // Reset pulse in the middle of BYTE2
    i2c_start();
    write_byte(8'h34, 1'b0, ack); check("t7_ack_dev", ack, 1);
    write_byte(8'h0E, 1'b0, ack); check("t7_ack_b1", ack, 1);
    reset_n = 1'b0; #1;
    check("t7_async_oe", sda_oe, 0);
    check("t7_async_busy", busy, 0);
    dbg_addr = 5'd7; #1; check("t7_async_regs", dbg_data, 9'h000);
    wait_clks(3);
    reset_n = 1'b1;
    write_byte(8'h4A, 1'b0, ack); check("t7_nack_rest", ack, 0);
    check("t7_busy_rest", busy, 0);
    i2c_stop();
    check("t7_no_write", wr_cnt, 6);
    write_reg(7'h05, 9'h123, "t7_after");
    check("t7_wr_cnt_after", wr_cnt, 7);
    check("t7_reg_addr", reg_addr, 7'h05);
    check("t7_reg_data", reg_data, 9'h123);
    dbg_addr = 5'd5; #1; check("t7_dbg5", dbg_data, 9'h123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ac_i2c_slave.md
AC_I2C_SLAVE -- requirements
Module: ac_i2c_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit I2C device address it responds to (SSM2603 CSB=0).
REQ-002 SHALL have parameter FILT_LEN, default 4, the number of consecutive equal synchronized samples needed to accept an SCL/SDA level change.
REQ-003 SHALL have port clk, input, 1 bit: system clock, at least 20x the SCL frequency.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port scl_i, input, 1 bit: I2C clock line as sampled from the pad.
REQ-006 SHALL have port sda_i, input, 1 bit: I2C data line as sampled from the pad.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain ACK); 0 releases SDA.
REQ-008 SHALL have port reg_wr, output, 1 bit: one-cycle strobe marking a committed register write.
REQ-009 SHALL have port reg_addr, output, 7 bits: register address of the last committed write.
REQ-010 SHALL have port reg_data, output, 9 bits: data of the last committed write.
REQ-011 SHALL have port dbg_addr, input, 5 bits: register file read address.
REQ-012 SHALL have port dbg_data, output, 9 bits: register file contents at dbg_addr, combinational read.
REQ-013 SHALL have port busy, output, 1 bit: 1 from an accepted START until the next STOP or return to IDLE.

Function
REQ-014 SHALL pass scl_i and sda_i through a 2-FF synchronizer, then through a FILT_LEN-sample glitch filter; all decoding below uses only the filtered levels.
REQ-015 SHALL detect START as filtered SDA 1->0 while filtered SCL=1, and STOP as filtered SDA 0->1 while filtered SCL=1.
REQ-016 SHALL sample SDA on each filtered SCL rising edge, MSB first.
REQ-017 SHALL change sda_oe only on filtered SCL falling edges.
REQ-018 SHALL implement the FSM states IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-019 START from any state SHALL go to ADDR, clear the bit counter, set sda_oe=0 and discard any partial transaction.
REQ-020 STOP from any state SHALL go to IDLE and set sda_oe=0, with no write committed.
REQ-021 After 8 bits in ADDR: if bits[7:1]==DEV_ADDR and bit0==0 (write), the falling SCL edge SHALL set sda_oe=1 and enter ACK_A; otherwise the block SHALL enter IGNORE with sda_oe=0 (NACK).
REQ-022 In ACK_A/ACK_1, the falling SCL edge ending the ACK clock SHALL release sda_oe and enter BYTE1/BYTE2 respectively; BYTE1 and BYTE2 SHALL each ACK after 8 bits.
REQ-023 On the falling SCL edge ending ACK_2, the block SHALL release sda_oe, pulse reg_wr for exactly one clk, latch reg_addr=byte1[7:1] and reg_data={byte1[0],byte2}, and enter IGNORE.
REQ-024 IGNORE SHALL NACK every further byte (sda_oe=0) and leave only on START or STOP.
REQ-025 The register file SHALL hold 32 entries of 9 bits; a commit with reg_addr<32 SHALL write entry reg_addr[4:0], and reg_addr>=32 SHALL pulse reg_wr without writing the file.
REQ-026 A commit with reg_addr==7'h0F (SSM2603 software reset) SHALL clear all 32 entries to 0 in the same cycle, overriding the normal write.
REQ-027 The block SHALL not support read transfers (R/W=1 is NACKed) and SHALL never stretch SCL.

Reset
REQ-028 With reset_n=0 the block SHALL asynchronously set state=IDLE, sda_oe=0, reg_wr=0, reg_addr=0, reg_data=0, busy=0, all register entries=0, and the filters and synchronizers to 1 (bus idle).
REQ-029 After reset_n deasserts, the block SHALL need a START before it acknowledges anything; if reset occurs mid-transfer, the remainder of that transfer SHALL be ignored.

Verification
REQ-030 The bench SHALL check: START, 0x34, 0x0E, 0x4A, STOP -> ACK on all 3 bytes, one reg_wr pulse, reg_addr=0x07, reg_data=0x04A, dbg_data[7]=0x04A.
REQ-031 The bench SHALL check: START, 0x36 (wrong address) -> sda_oe stays 0 for the whole transfer and no reg_wr.
REQ-032 The bench SHALL check: START, 0x35 (read) -> NACK and busy=1 until STOP.
REQ-033 The bench SHALL check: START, 0x34, 0x0E, repeated START, 0x34, 0x10, 0x01, STOP -> exactly one write, addr=0x08, data=0x001.
REQ-034 The bench SHALL check: after several writes, a write to addr 0x0F -> all dbg_data reads return 0; a 1-cycle SDA glitch while SCL is high causes no START/STOP.
REQ-035 The bench SHALL check: reset_n pulsed low during BYTE2 -> sda_oe=0 immediately, no reg_wr, and the following valid transaction succeeds.
